aes0_ct_buffer: RTL
===================

AES0_CT_BUFFER -- requirements
Module: aes0_ct_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of 128-bit ciphertext entries (power of two, 2..16).
REQ-002 SHALL have parameter WORD_W, default 32, meaning the output word width (fixed 32; other values unsupported).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ct_i, input, 128, ciphertext from the AES core.
REQ-006 SHALL have port ct_valid_i, input, 1, AES core result-valid level.
REQ-007 SHALL have port debug_mode_i, input, 1, debug mode; buffered ciphertext must not leave the block.
REQ-008 SHALL have port lock_i, input, 1, read lock (register-lock bit for the ciphertext region).
REQ-009 SHALL have port clr_i, input, 1, synchronous flush plus sticky-flag clear.
REQ-010 SHALL have port out_valid_o, output, 1, output word valid.
REQ-011 SHALL have port out_ready_i, input, 1, consumer ready.
REQ-012 SHALL have port out_data_o, output, 32, output word.
REQ-013 SHALL have port out_last_o, output, 1, the word is the last (bits 127:96) of its entry.
REQ-014 SHALL have port count_o, output, $clog2(DEPTH)+1, number of occupied entries.
REQ-015 SHALL have port overflow_o, output, 1, sticky dropped-capture flag.

Function
REQ-016 SHALL register ct_valid_i into ct_valid_q; capture event = ct_valid_i & ~ct_valid_q & ~debug_mode_i & ~clr_i.
REQ-017 SHALL write ct_i into the tail entry at the end of the capture-event cycle; a level held high SHALL yield exactly one capture.
REQ-018 SHALL implement a circular FIFO: head/tail pointers wrap from DEPTH-1 to 0, with a separate occupancy counter.
REQ-019 SHALL assert out_valid_o = (count != 0) & ~lock_i & ~debug_mode_i; the first word is visible the cycle after the capture edge.
REQ-020 SHALL drive out_data_o from the head entry, selected by a 2-bit word index: 0 -> [31:0], 1 -> [63:32], 2 -> [95:64], 3 -> [127:96]; out_data_o SHALL be 0 whenever out_valid_o = 0.
REQ-021 SHALL, on handshake (out_valid_o & out_ready_i), increment the word index; at index 3 it SHALL wrap to 0, pop the head, and zero that entry.
REQ-022 SHALL assert out_last_o = out_valid_o & (index == 3).
REQ-023 SHALL make out_valid_o/out_data_o stable while out_ready_i = 0, except when forced low by lock_i, debug_mode_i or clr_i.
REQ-024 SHALL, when a capture occurs with count == DEPTH and no pop in the same cycle, drop the capture, leave contents unchanged, and set overflow_o.
REQ-025 SHALL, when a capture and a pop occur in the same cycle with the FIFO full, accept the capture; count stays at DEPTH and overflow is not set.
REQ-026 SHALL, when a capture and a pop occur in the same cycle otherwise, leave count unchanged.
REQ-027 SHALL, while lock_i = 1, hold the word index and contents, continue accepting captures, and resume from the held index on release.
REQ-028 SHALL, on any cycle with debug_mode_i = 1, flush: zero all entries, pointers, index and count on the next edge; overflow_o is preserved.
REQ-029 SHALL, on clr_i = 1, perform the debug flush and also clear overflow_o; clr_i wins over a simultaneous capture or handshake.
REQ-030 SHALL use a state machine: EMPTY (count 0) and HOLD (count > 0, index 0, no word consumed) transition to STREAM after the first handshake, STREAM returns to HOLD on pop with count > 1 remaining, and to EMPTY on pop of the last entry; a flush moves any state to EMPTY.

Reset
REQ-031 SHALL, on rst_i = 1, clear immediately (asynchronously): all entries = 0, pointers = 0, index = 0, count_o = 0, overflow_o = 0, ct_valid_q = 0, out_valid_o = 0, out_data_o = 0, out_last_o = 0.
REQ-032 SHALL treat ct_valid_i high at reset release as a capture only if it is still high on the first edge after release (ct_valid_q = 0 then).
REQ-033 SHALL, if reset asserts mid-stream, discard the partial entry; no word of it appears after release.

Verification
REQ-034 Single capture: ct_i = 0x00112233_44556677_8899AABB_CCDDEEFF, ct_valid_i high for 5 cycles, out_ready_i = 1 -> exactly 4 words CCDDEEFF, 8899AABB, 44556677, 00112233, out_last_o on the 4th, count_o returns to 0.
REQ-035 Overflow: 5 captures with out_ready_i = 0 (DEPTH 4) -> count_o = 4, overflow_o = 1, the 5th value is never output; clr_i -> count_o = 0, overflow_o = 0.
REQ-036 Full with simultaneous pop: FIFO full, handshake on index 3 in the same cycle as a capture -> count_o stays 4, overflow_o = 0, the new value is output last.
REQ-037 Lock: lock_i = 1 after word 1 of an entry -> out_valid_o = 0; on release, output resumes with word 2 (bits 95:64).
REQ-038 Debug: 2 entries buffered, debug_mode_i pulsed 1 cycle -> out_valid_o = 0 immediately, count_o = 0 next cycle, ct_valid_i rising during debug not captured.
REQ-039 Reset mid-stream: rst_i asserted after word 2 -> all outputs 0 in the same cycle; after release, nothing is output until a new ct_valid_i rising edge.

Source files
------------

// File: rtl/aes0_ct_buffer.sv
// rtl/aes0_ct_buffer.sv - ciphertext capture FIFO with 32-bit word read-out
//
// Ports:
//   clk_i          clock, all state changes on rising edge
//   rst_i          asynchronous active-high reset
//   ct_i           128-bit ciphertext from the AES core
//   ct_valid_i     AES result-valid level (rising edge captures one entry)
//   debug_mode_i   debug mode: output blocked, buffer flushed
//   lock_i         read lock: output blocked, position held
//   clr_i          synchronous flush plus overflow clear
//   out_valid_o    output word valid
//   out_ready_i    consumer ready
//   out_data_o     output word, zero when not valid
//   out_last_o     word is bits 127:96 of its entry
//   count_o        number of occupied entries
//   overflow_o     sticky flag: a capture was dropped while full
module aes0_ct_buffer #(
   parameter int DEPTH  = 4,
   parameter int WORD_W = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [127:0]             ct_i,
   input  logic                     ct_valid_i,
   input  logic                     debug_mode_i,
   input  logic                     lock_i,
   input  logic                     clr_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [WORD_W-1:0]        out_data_o,
   output logic                     out_last_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_HOLD,
      ST_STREAM
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [127:0]    mem [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic [1:0]      idx;
   logic            ov;
   logic            ct_valid_q;

   logic            flush;
   logic            cap;
   logic            full;
   logic            out_valid;
   logic            hs;
   logic            pop;
   logic            push;
   logic            drop;
   logic [127:0]    head_entry;
   logic [31:0]     word;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign flush = debug_mode_i | clr_i;
   assign cap   = ct_valid_i & ~ct_valid_q & ~flush;
   assign full  = (count == CW'(DEPTH));

   // State is EMPTY exactly when count is zero, so it doubles as the
   // occupancy test. clr_i also blanks the output so a flushing cycle
   // can never complete a handshake.
   assign out_valid = (state != ST_EMPTY) & ~lock_i & ~flush;
   assign hs        = out_valid & out_ready_i;
   assign pop       = hs & (idx == 2'd3);
   // When full, a same-cycle pop frees the slot the capture needs.
   assign push      = cap & (~full | pop);
   assign drop      = cap & full & ~pop;

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + CW'(1);
      end else if (pop && !push) begin
         count_next = count - CW'(1);
      end
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY:  if (push) state_next = ST_HOLD;
            ST_HOLD:   if (hs) state_next = ST_STREAM;
            ST_STREAM: if (pop) state_next = (count_next != '0) ? ST_HOLD : ST_EMPTY;
            default:   state_next = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         idx        <= '0;
         ov         <= 1'b0;
         ct_valid_q <= 1'b0;
      end else begin
         ct_valid_q <= ct_valid_i;
         if (flush) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            idx   <= '0;
            if (clr_i) ov <= 1'b0;
         end else begin
            if (hs) idx <= idx + 2'd1;
            if (pop) begin
               mem[head] <= '0;
               head      <= ptr_inc(head);
            end
            // When full, head == tail: this later write must win over the
            // zeroing of the popped entry above.
            if (push) begin
               mem[tail] <= ct_i;
               tail      <= ptr_inc(tail);
            end
            count <= count_next;
            if (drop) ov <= 1'b1;
         end
      end
   end

   assign head_entry = mem[head];

   always_comb begin
      word = '0;
      case (idx)
         2'd0: word = head_entry[31:0];
         2'd1: word = head_entry[63:32];
         2'd2: word = head_entry[95:64];
         2'd3: word = head_entry[127:96];
         default: word = '0;
      endcase
   end

   assign out_valid_o = out_valid;
   assign out_data_o  = out_valid ? word : '0;
   assign out_last_o  = out_valid & (idx == 2'd3);
   assign count_o     = count;
   assign overflow_o  = ov;

endmodule
